// File: rtl/alu_cc_pipe_if.sv
// Request/response bundle for alu_cc_pipe: request side (in_*) and registered result side (out_*).
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both 1.
interface alu_cc_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_fun;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [2:0]       cc;

  modport master (
    output in_valid, alu_fun, alu_a, alu_b, set_cc, out_ready,
    input  in_ready, out_valid, result, err, cc
  );

  modport slave (
    input  in_valid, alu_fun, alu_a, alu_b, set_cc, out_ready,
    output in_ready, out_valid, result, err, cc
  );
endinterface

// File: rtl/alu_cc_pipe.sv
// Single-stage ALU (ADD/SUB/AND/XOR) with a one-entry registered output and a
// {ZF,SF,OF} condition-code register updated on request.
module alu_cc_pipe #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input logic          clk,
  input logic          rst,
  alu_cc_pipe_if.slave bus
);

  localparam logic [3:0] FUN_ADD = 4'd0;
  localparam logic [3:0] FUN_SUB = 4'd1;
  localparam logic [3:0] FUN_AND = 4'd2;
  localparam logic [3:0] FUN_XOR = 4'd3;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic [2:0]       cc_q;

  logic             accept;
  logic             legal;
  logic [WIDTH-1:0] next_result;
  logic             next_of;
  logic [2:0]       next_cc;

  // The output register frees up in the same cycle it is consumed, so a full stream sustains one op per cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    legal       = 1'b1;
    next_result = '0;
    next_of     = 1'b0;
    unique case (bus.alu_fun)
      FUN_ADD: begin
        next_result = bus.alu_b + bus.alu_a;
        next_of     = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                      (next_result[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      FUN_SUB: begin
        next_result = bus.alu_b - bus.alu_a;
        next_of     = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                      (next_result[WIDTH-1] != bus.alu_b[WIDTH-1]);
      end
      FUN_AND: next_result = bus.alu_a & bus.alu_b;
      FUN_XOR: next_result = bus.alu_a ^ bus.alu_b;
      default: legal = 1'b0;
    endcase
    next_cc = {(next_result == '0), next_result[WIDTH-1], next_of};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      cc_q        <= CC_RESET;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= next_result;
      err_q       <= !legal;
      if (legal && bus.set_cc) cc_q <= next_cc;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.cc        = cc_q;

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Directed bench for alu_cc_pipe: stimulus pushes hand-computed {result,err,cc}
// into a queue on acceptance; a negedge monitor pops and compares on each consumed output.
module tb_alu_cc_pipe;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   streaming = 1'b0;

  logic [W+3:0] exp_q[$];
  int           stream_cycles[$];

  alu_cc_pipe_if #(.WIDTH(W)) bus ();

  alu_cc_pipe #(.WIDTH(W), .CC_RESET(3'b100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // driver
  task automatic send(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sc, input logic [W-1:0] exp_r, input logic exp_e,
                      input logic [2:0] exp_c);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_fun  = fun;
    bus.alu_a    = a;
    bus.alu_b    = b;
    bus.set_cc   = sc;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({exp_r, exp_e, exp_c});
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        logic [W+3:0] e;
        e = exp_q.pop_front();
        chk("result", bus.result, e[W+3:4]);
        chk("err", {63'd0, bus.err}, {63'd0, e[3]});
        chk("cc", {61'd0, bus.cc}, {61'd0, e[2:0]});
        if (streaming) stream_cycles.push_back(cycle);
      end
    end
  end

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_fun   = 4'd0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.set_cc    = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_err", {63'd0, bus.err}, 64'd0);
    chk("rst_cc", {61'd0, bus.cc}, 64'd4);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    bus.out_ready = 1'b1;
    send(4'd3, ONES, ONES, 1'b1, 64'd0, 1'b0, 3'b100);
    send(4'd0, MAXP, MAXP, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b011);
    send(4'd1, 64'd1, 64'd0, 1'b0, ONES, 1'b0, 3'b011);
    send(4'd1, 64'd5, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b010);
    send(4'd1, 64'd1, MINN, 1'b1, MAXP, 1'b0, 3'b001);
    send(4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1,
         64'hF000_F000_F000_F000, 1'b0, 3'b010);
    send(4'd0, 64'd1, ONES, 1'b1, 64'd0, 1'b0, 3'b100);
    send(4'd7, 64'd9, 64'd9, 1'b1, 64'd0, 1'b1, 3'b100);
    send(4'd15, ONES, 64'd1, 1'b0, 64'd0, 1'b1, 3'b100);
    send(4'd3, 64'h0F, 64'hF0, 1'b0, 64'hFF, 1'b0, 3'b100);
    idle(2);

    // backpressure: first result held, second request stalled
    bus.out_ready = 1'b0;
    send(4'd0, 64'd2, 64'd3, 1'b0, 64'd5, 1'b0, 3'b100);
    bus.in_valid = 1'b1;
    bus.alu_fun  = 4'd1;
    bus.alu_a    = 64'd4;
    bus.alu_b    = 64'd10;
    bus.set_cc   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stall_result", bus.result, 64'd5);
      chk("stall_cc", {61'd0, bus.cc}, 64'd4);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(4'd1, 64'd4, 64'd10, 1'b1, 64'd6, 1'b0, 3'b000);
    idle(2);

    // streaming: one ADD per cycle, results on consecutive cycles
    streaming = 1'b1;
    for (int i = 1; i <= 10; i++)
      send(4'd0, 64'(i), 64'(100 * i), 1'b1, 64'(101 * i), 1'b0, 3'b000);
    idle(3);
    streaming = 1'b0;
    chk("stream_count", 64'(stream_cycles.size()), 64'd10);
    if (stream_cycles.size() == 10)
      chk("stream_span", 64'(stream_cycles[9] - stream_cycles[0]), 64'd9);

    // reset with an unconsumed result held
    bus.out_ready = 1'b0;
    send(4'd0, 64'd1, 64'd1, 1'b1, 64'd2, 1'b0, 3'b000);
    @(negedge clk);
    chk("held_before_rst", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("post_rst_result", bus.result, 64'd0);
    chk("post_rst_cc", {61'd0, bus.cc}, 64'd4);
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(4'd3, 64'h3C, 64'h0F, 1'b1, 64'h33, 1'b0, 3'b000);
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
